// File: rtl/uart_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
//   rx_state_t : serial receiver FSM states
//   ld_state_t : word-loader FSM states
package uart_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned BYTES_PER_WORD       = 4;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_CNT_LO,
        L_CNT_HI,
        L_DATA,
        L_DONE
    } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   rx_i          : asynchronous serial input, idle high
//   byte_o        : last received byte (LSB first on the wire)
//   byte_valid_o  : one-cycle pulse when byte_o holds a well-framed byte
//   stop_err_o    : one-cycle pulse when the stop bit was sampled low
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] byte_o,
    output logic                      byte_valid_o,
    output logic                      stop_err_o
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W   = $clog2(UART_DATA_BITS);
    localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;

    logic                      rx_meta_q, rx_s_q;
    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      valid_q, valid_d;
    logic                      serr_q, serr_d;

    // Synchronizer and FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= R_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            serr_q    <= serr_d;
        end
    end

    // Next-state: start edge, mid-bit sampling, stop check
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        serr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!rx_s_q) begin
                    state_d = R_START;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            R_START: begin
                if (baud_q == CNT_W'(HALF_M1)) begin
                    baud_d  = '0;
                    // Line back high at mid start bit: glitch, not a frame
                    state_d = rx_s_q ? R_IDLE : R_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (baud_q == CNT_W'(FULL_M1)) begin
                    baud_d = '0;
                    byte_d = {rx_s_q, byte_q[UART_DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            R_STOP: begin
                if (baud_q == CNT_W'(FULL_M1)) begin
                    baud_d  = '0;
                    state_d = R_IDLE;
                    valid_d = rx_s_q;
                    serr_d  = ~rx_s_q;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign stop_err_o   = serr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a 16-bit little-endian word count followed by
// little-endian 32-bit words over UART and writes them to instruction
// memory from word address 0 upward.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   rx_i        : serial input, idle high
//   load_en     : level; 1 accepts a stream, 0 holds loader idle and cleared
//   imem_we     : one-cycle write strobe
//   imem_addr   : word address for imem_we (wraps modulo 2^ADDR_W)
//   imem_wdata  : instruction word for imem_we
//   load_done   : high once all declared words are written
//   frame_err   : sticky, a byte arrived with a low stop bit
module uart_imem_loader
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    input  logic              load_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic              frame_err
);

    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W = BYTES_PER_WORD * UART_DATA_BITS;
    localparam int unsigned CNT_W  = 16;

    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_byte_valid;
    logic                      rx_stop_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_byte_valid),
        .stop_err_o  (rx_stop_err)
    );

    ld_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  word_next;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;

    // Loader state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= L_IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Current word with the incoming byte dropped into lane idx_q
    always_comb begin
        word_next = word_q;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word_next[i*UART_DATA_BITS +: UART_DATA_BITS] = rx_byte;
            end
        end
    end

    // Loader next-state and outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        // load_done trails the final write by one cycle
        done_d  = (state_q == L_DONE);
        ferr_d  = ferr_q | rx_stop_err;

        if (!load_en) begin
            // Abort: drop any partial word and clear status; a byte
            // arriving this cycle is discarded
            state_d = L_IDLE;
            cnt_d   = '0;
            words_d = '0;
            addr_d  = '0;
            idx_d   = '0;
            word_d  = '0;
            done_d  = 1'b0;
            ferr_d  = 1'b0;
        end else begin
            case (state_q)
                L_IDLE: state_d = L_CNT_LO;
                L_CNT_LO: begin
                    if (rx_byte_valid) begin
                        cnt_d[7:0] = rx_byte;
                        state_d    = L_CNT_HI;
                    end
                end
                L_CNT_HI: begin
                    if (rx_byte_valid) begin
                        cnt_d[15:8] = rx_byte;
                        addr_d      = '0;
                        idx_d       = '0;
                        words_d     = '0;
                        word_d      = '0;
                        state_d     = ({rx_byte, cnt_q[7:0]} == '0) ? L_DONE : L_DATA;
                    end
                end
                L_DATA: begin
                    if (rx_byte_valid) begin
                        if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = word_next;
                            addr_d  = addr_q + ADDR_W'(1);
                            words_d = words_q + CNT_W'(1);
                            idx_d   = '0;
                            word_d  = '0;
                            if (words_q + CNT_W'(1) == cnt_q) begin
                                state_d = L_DONE;
                            end
                        end else begin
                            word_d = word_next;
                            idx_d  = idx_q + IDX_W'(1);
                        end
                    end
                end
                L_DONE: ;
                default: state_d = L_IDLE;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign load_done  = done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed self-checking bench for uart_imem_loader (CLKS_PER_BIT = 16).
module tb_uart_imem_loader;
    import uart_pkg::*;

    localparam int unsigned CPB    = 16;
    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx;
    logic              load_en;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              load_done;
    logic              frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Write / byte log filled by the monitor
    logic [ADDR_W-1:0] wr_addr [8];
    logic [31:0]       wr_data [8];
    int                wr_cyc  [8];
    int                wr_n = 0;
    int                bv_n = 0;
    int                bv_last_cyc = 0;
    int                ld_rise_cyc = -1;
    logic              ld_prev = 1'b0;
    int                cyc = 0;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx),
        .load_en   (load_en),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_n < 8) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
        if (u_dut.rx_byte_valid) begin
            bv_n++;
            bv_last_cyc = cyc;
        end
        if (load_done && !ld_prev) ld_rise_cyc = cyc;
        ld_prev = load_done;
    end

    task automatic clear_log();
        @(posedge clk);
        wr_n        = 0;
        bv_n        = 0;
        ld_rise_cyc = -1;
        @(negedge clk);
    endtask

    // Called at a negedge; leaves the line idle for two bit times after the stop bit
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic restart_load();
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", imem_we); end
        n_checks++;
        if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: got addr %0h data %h expected 0 0", imem_addr, imem_wdata);
        end
        n_checks++;
        if (load_done !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: got done %b ferr %b expected 0 0", load_done, frame_err);
        end
    endtask

    task automatic test_basic();
        load_en = 1'b1;
        clear_log();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hB3, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'hB5, 1'b1); send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (wr_n !== 2) begin n_fail++; $display("FAIL basic_wr_count: got %0d expected 2", wr_n); end
        n_checks++;
        if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h0000_0513) begin
            n_fail++; $display("FAIL basic_wr0: got %0h/%h expected 0/00000513", wr_addr[0], wr_data[0]);
        end
        n_checks++;
        if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00B5_05B3) begin
            n_fail++; $display("FAIL basic_wr1: got %0h/%h expected 1/00b505b3", wr_addr[1], wr_data[1]);
        end
        n_checks++;
        if (wr_cyc[1] !== bv_last_cyc + 1) begin
            n_fail++; $display("FAIL basic_latency: got cycle %0d expected %0d", wr_cyc[1], bv_last_cyc + 1);
        end
        n_checks++;
        if (ld_rise_cyc !== wr_cyc[1] + 1) begin
            n_fail++; $display("FAIL basic_done_rise: got cycle %0d expected %0d", ld_rise_cyc, wr_cyc[1] + 1);
        end
        n_checks++;
        if (load_done !== 1'b1 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_status: got done %b ferr %b expected 1 0", load_done, frame_err);
        end
    endtask

    task automatic test_glitch();
        load_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b0) begin n_fail++; $display("FAIL drop_done_clear: got %b expected 0", load_done); end
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_checks++;
        if (bv_n !== 0) begin n_fail++; $display("FAIL glitch_no_byte: got %0d bytes expected 0", bv_n); end
        n_checks++;
        if (u_dut.state_q !== L_CNT_LO) begin
            n_fail++; $display("FAIL glitch_state: got %0d expected %0d", u_dut.state_q, L_CNT_LO);
        end
        send_byte(8'h55, 1'b1);
        n_checks++;
        if (bv_n !== 1 || u_dut.rx_byte !== 8'h55) begin
            n_fail++; $display("FAIL glitch_next_byte: got %0d bytes value %h expected 1 55", bv_n, u_dut.rx_byte);
        end
        n_checks++;
        if (u_dut.state_q !== L_CNT_HI) begin
            n_fail++; $display("FAIL glitch_next_state: got %0d expected %0d", u_dut.state_q, L_CNT_HI);
        end
    endtask

    task automatic test_frame_err();
        restart_load();
        clear_log();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        n_checks++;
        if (wr_n !== 1 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h4433_2211) begin
            n_fail++; $display("FAIL ferr_write: got n %0d %0h/%h expected 1 0/44332211", wr_n, wr_addr[0], wr_data[0]);
        end
        n_checks++;
        if (load_done !== 1'b1) begin n_fail++; $display("FAIL ferr_done: got %b expected 1", load_done); end
        load_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
    endtask

    task automatic test_zero_count();
        restart_load();
        clear_log();
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        n_checks++;
        if (load_done !== 1'b1 || wr_n !== 0) begin
            n_fail++; $display("FAIL zero_done: got done %b writes %0d expected 1 0", load_done, wr_n);
        end
        send_byte(8'h13, 1'b1);
        n_checks++;
        if (wr_n !== 0 || load_done !== 1'b1) begin
            n_fail++; $display("FAIL zero_ignore: got writes %0d done %b expected 0 1", wr_n, load_done);
        end
    endtask

    task automatic test_abort();
        restart_load();
        clear_log();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
        load_en = 1'b0;
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wr_n !== 0 || load_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_nowrite: got writes %0d done %b expected 0 0", wr_n, load_done);
        end
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        n_checks++;
        if (wr_n !== 1 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL abort_reload: got n %0d %0h/%h expected 1 0/deadbeef", wr_n, wr_addr[0], wr_data[0]);
        end
        n_checks++;
        if (load_done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b expected 1", load_done); end
    endtask

    task automatic test_reset_mid();
        restart_load();
        clear_log();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        // Partial byte 0x13: start bit, bit0, half of bit1
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 || load_done !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got we %b addr %0h data %h done %b ferr %b expected all 0",
                               imem_we, imem_addr, imem_wdata, load_done, frame_err);
        end
        n_checks++;
        if (u_dut.state_q !== L_IDLE || u_dut.u_rx.state_q !== R_IDLE) begin
            n_fail++; $display("FAIL midrst_fsms: got ld %0d rx %0d expected 0 0", u_dut.state_q, u_dut.u_rx.state_q);
        end
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_n !== 0) begin n_fail++; $display("FAIL midrst_nowrite: got %0d expected 0", wr_n); end
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        n_checks++;
        if (wr_n !== 1 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL midrst_reload: got n %0d %0h/%h expected 1 0/12345678", wr_n, wr_addr[0], wr_data[0]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        load_en = 1'b0;
        rx      = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_basic();
        test_glitch();
        test_frame_err();
        test_zero_count();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
